instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
Fetch stage that sits directly upstream of programMemory. It owns the program counter and drives programMemory's asynchronous-read address, then latches the returned instruction into an instruction register (IR) for the decoder. It resolves jumps and relative branches signalled by the decode stage, supports stall and halt, and adds one bubble cycle after any redirect.

Parameters:
P_SIZE, 6, program address width; matches programMemory.
I_SIZE, 24, instruction width; matches programMemory.
OFFSET_SIZE, 6, width of the signed branch offset; must be <= P_SIZE, otherwise an elaboration error is raised.
RESET_ADDR, 0, PC value after reset.

Ports:
clk  in  1  clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
address  out  P_SIZE  to programMemory; equals pc combinationally.
instruction  in  I_SIZE  from programMemory; valid in the same cycle.
stall  in  1  hold all state.
jump  in  1  absolute redirect for the instruction in IR.
jump_addr  in  P_SIZE  jump target.
branch  in  1  relative redirect for the instruction in IR.
branch_offset  in  OFFSET_SIZE  signed offset, relative to ir_pc.
halt  in  1  stop fetching.
ir  out  I_SIZE  registered instruction.
ir_pc  out  P_SIZE  address of the instruction in ir.
ir_valid  out  1  ir holds a valid instruction.
halted  out  1  high while in the HALTED state.

Behaviour:
- Reset values: pc=RESET_ADDR, ir=0, ir_pc=0, ir_valid=0, halted=0, state=FILL.
- Reset takes priority over all other inputs, including stall, and applies even mid-operation.
- States are FILL, RUN and HALTED.
- FILL: ir<=instruction, ir_pc<=pc, ir_valid<=1, pc<=pc+1, then go to RUN. jump, branch and halt are ignored in FILL.
- RUN: the redirect inputs refer to the instruction currently in ir. Priority is stall > halt > jump > branch > sequential.
  - Sequential: same update as FILL, and stay in RUN.
  - jump: pc<=jump_addr, ir_valid<=0, go to FILL. This discards the wrong-path fetch and gives exactly one bubble.
  - branch: pc<=ir_pc + sign_extend(branch_offset), computed modulo 2^P_SIZE, ir_valid<=0, go to FILL.
  - halt: go to HALTED, ir_valid<=0, pc held, halted<=1.
- Stall, in any state: pc, ir, ir_pc, ir_valid and state all hold. Redirect and halt inputs presented during a stall are ignored, not queued.
- HALTED: all state holds; only reset exits.
- pc+1 wraps from 2^P_SIZE-1 to 0 with no flag. Branch targets wrap the same way.
- Latency: an instruction appears in ir one edge after its address is driven. A redirect costs one bubble cycle.

Optional Feature:
Macro INSTRUCTION_FETCH_LINK_EN.
- Defined: adds input ports call (1 bit) and ret (1 bit), plus a P_SIZE-bit link register that resets to 0.
  - call acts like jump using jump_addr, and also sets link<=ir_pc+1 (wrapping).
  - ret sets pc<=link, clears ir_valid and goes to FILL.
  - RUN priority becomes stall > halt > jump/call > ret > branch. If call and jump are both high, call's link write still happens.
- Undefined: the ports and the register are absent, and behaviour is exactly as described above.

Decomposition:
- Package fetch_pkg holds:
  - enum fetch_state_t {FILL, RUN, HALTED};
  - default constants FETCH_P_SIZE=6 and FETCH_I_SIZE=24;
  - function sext_offset() for the sign extension.
- One combinational sub-module, pc_next_logic: the next-PC mux (sequential, jump, branch, link). The FSM and registers stay in the top module.

Test Plan:
- Reset sequential run: the bench memory is loaded from prog.hex.
  - Reset, then release -> address=0 and ir_valid=0.
  - After 1 edge -> ir=mem[0], ir_pc=0, ir_valid=1, address=1.
  - After 63 further edges -> address wraps 63->0.
- Jump: with ir_pc=5, pulse jump with jump_addr=0x20.
  - Next edge -> address=0x20, ir_valid=0.
  - Following edge -> ir=mem[0x20], ir_pc=0x20.
- Branch arithmetic:
  - ir_pc=3, offset=6'b111110 (-2) -> address=1.
  - ir_pc=62, offset=+3 -> address=1 (wrap).
  - Each case is followed by one cycle with ir_valid=0.
- Stall: stall for 3 cycles at ir_pc=8 with jump=1 and jump_addr=0x30.
  - All outputs are unchanged for the 3 cycles.
  - After release, with jump=0, the next edge loads ir_pc=9 and the jump is not taken.
- Halt then reset: halt at ir_pc=10.
  - -> halted=1, ir_valid=0, address=11, held for 5 cycles despite jump and branch.
  - Reset, asserted together with stall -> address=0, halted=0, state FILL.
- Link (macro defined): call at ir_pc=12 with jump_addr=0x28 -> address=0x28; later ret -> address=13, one bubble.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types, default widths and the branch-offset sign-extension helper for the fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_P_SIZE = 6;
  localparam int unsigned FETCH_I_SIZE = 24;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    HALTED
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_JUMP,
    PC_BRANCH,
    PC_LINK
  } pc_sel_t;

  // Sign-extends the low 'width' bits of 'offset' to 32 bits.
  function automatic logic [31:0] sext_offset(input logic [31:0] offset,
                                              input int unsigned width);
    logic [31:0] shifted;
    shifted = offset << (32 - width);
    return 32'($signed(shifted) >>> (32 - width));
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC mux: sequential increment, absolute jump, relative branch or link return.
module pc_next_logic
  import fetch_pkg::*;
#(
  parameter int unsigned P_SIZE      = FETCH_P_SIZE,
  parameter int unsigned OFFSET_SIZE = 6
) (
  input  pc_sel_t                i_sel,
  input  logic [P_SIZE-1:0]      i_pc,
  input  logic [P_SIZE-1:0]      i_ir_pc,
  input  logic [P_SIZE-1:0]      i_jump_addr,
  input  logic [P_SIZE-1:0]      i_link,
  input  logic [OFFSET_SIZE-1:0] i_branch_offset,
  output logic [P_SIZE-1:0]      o_next_pc
);

  logic [P_SIZE-1:0] w_branch_delta;

  // Truncating the 32-bit extension gives modulo-2^P_SIZE branch arithmetic.
  assign w_branch_delta = P_SIZE'(sext_offset(32'(i_branch_offset), OFFSET_SIZE));

  always_comb begin
    o_next_pc = i_pc + P_SIZE'(1);
    unique case (i_sel)
      PC_SEQ:    o_next_pc = i_pc + P_SIZE'(1);
      PC_JUMP:   o_next_pc = i_jump_addr;
      PC_BRANCH: o_next_pc = i_ir_pc + w_branch_delta;
      PC_LINK:   o_next_pc = i_link;
      default:   o_next_pc = i_pc + P_SIZE'(1);
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, latches programMemory output into IR, resolves redirects and halt.
// Optional call/ret with a link register when INSTRUCTION_FETCH_LINK_EN is defined.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned P_SIZE      = FETCH_P_SIZE,
  parameter int unsigned I_SIZE      = FETCH_I_SIZE,
  parameter int unsigned OFFSET_SIZE = 6,
  parameter int unsigned RESET_ADDR  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [P_SIZE-1:0]      address,
  input  logic [I_SIZE-1:0]      instruction,
  input  logic                   stall,
  input  logic                   jump,
  input  logic [P_SIZE-1:0]      jump_addr,
  input  logic                   branch,
  input  logic [OFFSET_SIZE-1:0] branch_offset,
  input  logic                   halt,
`ifdef INSTRUCTION_FETCH_LINK_EN
  input  logic                   call,
  input  logic                   ret,
`endif
  output logic [I_SIZE-1:0]      ir,
  output logic [P_SIZE-1:0]      ir_pc,
  output logic                   ir_valid,
  output logic                   halted
);

  if (OFFSET_SIZE > P_SIZE) begin : g_bad_offset_size
    $error("OFFSET_SIZE must not exceed P_SIZE");
  end

  logic [P_SIZE-1:0] r_pc;
  logic [P_SIZE-1:0] r_ir_pc;
  logic [I_SIZE-1:0] r_ir;
  logic              r_ir_valid;
  logic              r_halted;
  fetch_state_t      r_state;

  pc_sel_t           w_sel;
  logic              w_redirect;
  logic              w_halt_now;
  logic [P_SIZE-1:0] w_next_pc;
  logic [P_SIZE-1:0] w_link;
  logic              w_call;
  logic              w_ret;

`ifdef INSTRUCTION_FETCH_LINK_EN
  logic [P_SIZE-1:0] r_link;

  // Link is written whenever call wins arbitration, even if jump is also high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_link <= '0;
    end else if (!stall && r_state == RUN && !halt && call) begin
      r_link <= r_ir_pc + P_SIZE'(1);
    end
  end

  assign w_link = r_link;
  assign w_call = call;
  assign w_ret  = ret;
`else
  assign w_link = '0;
  assign w_call = 1'b0;
  assign w_ret  = 1'b0;
`endif

  // Redirects only apply in RUN, where they refer to the instruction held in IR.
  always_comb begin
    w_sel      = PC_SEQ;
    w_redirect = 1'b0;
    w_halt_now = 1'b0;
    if (r_state == RUN) begin
      if (halt) begin
        w_halt_now = 1'b1;
      end else if (jump || w_call) begin
        w_sel      = PC_JUMP;
        w_redirect = 1'b1;
      end else if (w_ret) begin
        w_sel      = PC_LINK;
        w_redirect = 1'b1;
      end else if (branch) begin
        w_sel      = PC_BRANCH;
        w_redirect = 1'b1;
      end
    end
  end

  pc_next_logic #(
    .P_SIZE      (P_SIZE),
    .OFFSET_SIZE (OFFSET_SIZE)
  ) u_pc_next_logic (
    .i_sel           (w_sel),
    .i_pc            (r_pc),
    .i_ir_pc         (r_ir_pc),
    .i_jump_addr     (jump_addr),
    .i_link          (w_link),
    .i_branch_offset (branch_offset),
    .o_next_pc       (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= P_SIZE'(RESET_ADDR);
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
      r_state    <= FILL;
    end else if (!stall) begin
      unique case (r_state)
        FILL: begin
          r_ir       <= instruction;
          r_ir_pc    <= r_pc;
          r_ir_valid <= 1'b1;
          r_pc       <= w_next_pc;
          r_state    <= RUN;
        end
        RUN: begin
          if (w_halt_now) begin
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b1;
            r_state    <= HALTED;
          end else if (w_redirect) begin
            r_pc       <= w_next_pc;
            r_ir_valid <= 1'b0;
            r_state    <= FILL;
          end else begin
            r_ir       <= instruction;
            r_ir_pc    <= r_pc;
            r_ir_valid <= 1'b1;
            r_pc       <= w_next_pc;
          end
        end
        HALTED: ;
        default: r_state <= FILL;
      endcase
    end
  end

  assign address  = r_pc;
  assign ir       = r_ir;
  assign ir_pc    = r_ir_pc;
  assign ir_valid = r_ir_valid;
  assign halted   = r_halted;

endmodule
